mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-low.
REQ-002 SHALL have ports: Instr  in  32  instruction-register output, stable from DECODE onward; ALUFlags  in  4  {N,Z,C,V} from ALU.
REQ-003 SHALL have write-strobe outputs, 1 bit each: PCWrite, IRWrite, RegWrite, MemWrite.
REQ-004 SHALL have select outputs: AdrSrc 1; ALUSrcA 2; ALUSrcB 2; ResultSrc 2; ImmSrc 2; RegSrc 2; ALUControl 4.

Function
REQ-005 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, in a 4-bit state register.
REQ-006 SHALL transition as follows:
- FETCH->DECODE.
- DECODE: Op=01->MEMADR; Op=00,I=0->EXECUTER; Op=00,I=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH (no-op).
- MEMADR: L=1->MEMRD; L=0->MEMWR.
- MEMRD->MEMWB.
- EXECUTER/EXECUTEI: cmd=10xx->FETCH; otherwise->ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-007 Field definitions: Op=Instr[27:26]; I=Instr[25]; cmd=Instr[24:21]; S=Instr[20]; L=Instr[20]; Rd=Instr[15:12]; cond=Instr[31:28].
REQ-008 SHALL drive per-state outputs; unlisted selects are 0:
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- MEMWR: AdrSrc=1, MemWrite=CondEx.
- EXECUTER: ALUSrcB=00.
- EXECUTEI: ALUSrcB=01.
- ALUWB: RegWrite=CondEx.
- BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
REQ-009 In MEMWB or ALUWB with Rd=1111, PCWrite SHALL equal CondEx in addition to RegWrite.
REQ-010 ALUControl SHALL equal cmd in EXECUTER/EXECUTEI, and 4'b0100 (ADD) in all other states.
REQ-011 ImmSrc SHALL equal Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01); all state-independent combinational.
REQ-012 SHALL hold a 4-bit flag register {N,Z,C,V}; CondEx SHALL be computed from cond against the stored flags per all 15 ARM codes (EQ..AL); cond=1111 SHALL give CondEx=0.
REQ-013 Flag update SHALL occur on the clock edge leaving EXECUTER/EXECUTEI, only if S=1 and CondEx=1.
REQ-014 Flag update scope: N,Z always; C,V only when cmd is in {0010 SUB, 0100 ADD, 1010 CMP, 1011 CMN}; C,V SHALL hold otherwise.
REQ-015 CondEx used in a state SHALL reflect the flags before any update in that same state, so an instruction never sees its own flag result.
REQ-016 Latency: DP with writeback 4 cycles; CMP/CMN/TST/TEQ 3; LDR 5; STR 4; B 3; Op=11 2.

Reset
REQ-017 reset=0 SHALL immediately force state=FETCH and flags=0000, independent of clk.
REQ-018 While reset=0, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0; other outputs SHALL take their FETCH values.
REQ-019 Reset asserted mid-instruction SHALL abandon the instruction with no further strobe.
REQ-020 The first rising edge after reset deasserts SHALL execute FETCH with full strobes.

Verification
REQ-021 ADD R1,R2,#5 (E2821005), flags 0000 -> states F,D,EXECUTEI,ALUWB; ALUControl=0100 in EXECUTEI; RegWrite=1 in ALUWB only; flags unchanged.
REQ-022 SUBS R0,R0,R0 (E0500000), ALUFlags=0110 in EXECUTER -> flags=0110 after that edge; next state ALUWB.
REQ-023 CMP R0,#0 (E3500000), ALUFlags=0100 -> F,D,EXECUTEI,F (3 cycles); RegWrite never 1; flags=0100.
REQ-024 BEQ (0A000002) with Z=0 -> BRANCH reached, PCWrite=0 in BRANCH. With Z=1 -> PCWrite=1 in BRANCH.
REQ-025 LDR R3,[R0,#8] (E5903008) -> F,D,MEMADR,MEMRD,MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (E5803008) -> MemWrite=1 in MEMWR only.
REQ-026 Assert reset in MEMRD with flags=1010 -> state=FETCH and flags=0000 before the next edge, all strobes 0. Op=11 instruction -> F,D,F with no writes.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: Moore sequencer, condition check against
// a stored NZCV flag register, and per-state datapath strobes/selects.
module mc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [3:0]  ALUControl
);

   localparam int unsigned FLAG_W = 4;
   localparam logic [3:0]  ALU_ADD = 4'b0100;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [FLAG_W-1:0]   r_flags;

   logic [1:0] w_op;
   logic       w_i;
   logic [3:0] w_cmd;
   logic       w_sl;
   logic [3:0] w_rd;
   logic [3:0] w_cond;
   logic       w_unused_bits;

   assign w_op          = Instr[27:26];
   assign w_i           = Instr[25];
   assign w_cmd         = Instr[24:21];
   assign w_sl          = Instr[20];
   assign w_rd          = Instr[15:12];
   assign w_cond        = Instr[31:28];
   assign w_unused_bits = ^{Instr[19:16], Instr[11:0]};

   // Condition evaluation against the stored (pre-update) flags
   logic w_n, w_z, w_c, w_v, w_cond_ex;
   assign {w_n, w_z, w_c, w_v} = r_flags;

   always_comb begin
      w_cond_ex = 1'b0;
      case (w_cond)
         4'b0000: w_cond_ex = w_z;
         4'b0001: w_cond_ex = ~w_z;
         4'b0010: w_cond_ex = w_c;
         4'b0011: w_cond_ex = ~w_c;
         4'b0100: w_cond_ex = w_n;
         4'b0101: w_cond_ex = ~w_n;
         4'b0110: w_cond_ex = w_v;
         4'b0111: w_cond_ex = ~w_v;
         4'b1000: w_cond_ex = w_c & ~w_z;
         4'b1001: w_cond_ex = ~w_c | w_z;
         4'b1010: w_cond_ex = (w_n == w_v);
         4'b1011: w_cond_ex = (w_n != w_v);
         4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
         4'b1101: w_cond_ex = w_z | (w_n != w_v);
         4'b1110: w_cond_ex = 1'b1;
         default: w_cond_ex = 1'b0;
      endcase
   end

   logic w_in_exec, w_flag_upd, w_cv_upd;
   assign w_in_exec  = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
   assign w_flag_upd = w_in_exec & w_sl & w_cond_ex;
   assign w_cv_upd   = (w_cmd == 4'b0010) || (w_cmd == 4'b0100) ||
                       (w_cmd == 4'b1010) || (w_cmd == 4'b1011);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Flag register: N,Z on any flag-setting op, C,V only for arithmetic ops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= '0;
      end else if (w_flag_upd) begin
         r_flags[3:2] <= ALUFlags[3:2];
         if (w_cv_upd) r_flags[1:0] <= ALUFlags[1:0];
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (w_op)
               2'b01:   w_next = S_MEMADR;
               2'b00:   w_next = w_i ? S_EXECUTEI : S_EXECUTER;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = w_sl ? S_MEMRD : S_MEMWR;
         S_MEMRD:    w_next = S_MEMWB;
         S_EXECUTER,
         S_EXECUTEI: w_next = (w_cmd[3:2] == 2'b10) ? S_FETCH : S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // Per-state outputs; strobes are masked while reset is held
   logic w_pcw, w_irw, w_rw, w_mw, w_rd_pc;
   assign w_rd_pc = (w_rd == 4'b1111);

   always_comb begin
      w_pcw      = 1'b0;
      w_irw      = 1'b0;
      w_rw       = 1'b0;
      w_mw       = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            w_irw     = 1'b1;
            w_pcw     = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: ALUSrcB = 2'b01;
         S_MEMRD:  AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            w_rw      = w_cond_ex;
            w_pcw     = w_cond_ex & w_rd_pc;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            w_mw   = w_cond_ex;
         end
         S_EXECUTER: ALUControl = w_cmd;
         S_EXECUTEI: begin
            ALUSrcB    = 2'b01;
            ALUControl = w_cmd;
         end
         S_ALUWB: begin
            w_rw  = w_cond_ex;
            w_pcw = w_cond_ex & w_rd_pc;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            w_pcw     = w_cond_ex;
         end
         default: ;
      endcase
   end

   assign PCWrite  = w_pcw & reset;
   assign IRWrite  = w_irw & reset;
   assign RegWrite = w_rw  & reset;
   assign MemWrite = w_mw  & reset;

   // State-independent decode of immediate and register-source selects
   assign ImmSrc = w_op;
   assign RegSrc = {w_op == 2'b01, w_op == 2'b10};

endmodule
